// File: rtl/mcb_port_arbiter.sv
// Round-robin arbiter sharing one MCB user port (cmd/wr/rd FIFOs) among N_CH burst clients.
// Write data is streamed into the port FIFO before the write command is issued.
module mcb_port_arbiter #(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  parameter int AW   = 30,
  parameter int BLW  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH-1:0]       req_we,
  input  logic [N_CH*AW-1:0]    req_addr,
  input  logic [N_CH*BLW-1:0]   req_bl,
  input  logic [N_CH*DW-1:0]    wr_data,
  input  logic [N_CH-1:0]       wr_valid,
  output logic [N_CH-1:0]       wr_ready,
  output logic [DW-1:0]         rd_data,
  output logic [N_CH-1:0]       rd_valid,
  output logic [N_CH-1:0]       grant,
  output logic [N_CH-1:0]       done,
  output logic                  busy,
  output logic                  p_cmd_en,
  output logic [2:0]            p_cmd_instr,
  output logic [BLW-1:0]        p_cmd_bl,
  output logic [AW-1:0]         p_cmd_byte_addr,
  input  logic                  p_cmd_full,
  output logic                  p_wr_en,
  output logic [DW-1:0]         p_wr_data,
  output logic [DW/8-1:0]       p_wr_mask,
  input  logic                  p_wr_full,
  output logic                  p_rd_en,
  input  logic [DW-1:0]         p_rd_data,
  input  logic                  p_rd_empty
);

  localparam int IW = $clog2(N_CH);
  localparam logic [IW:0] N_CH_W = (IW+1)'(N_CH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_CMD     = 3'd2,
    S_RD_DATA = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [IW-1:0]   g_q, g_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            we_q, we_d;
  logic [2:0]      instr_q, instr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BLW-1:0]  bl_q, bl_d;
  logic [BLW:0]    wcnt_q, wcnt_d;

  logic [AW-1:0]   addr_a [N_CH];
  logic [BLW-1:0]  bl_a   [N_CH];
  logic [DW-1:0]   wdat_a [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign addr_a[gi] = req_addr[gi*AW +: AW];
    assign bl_a[gi]   = req_bl[gi*BLW +: BLW];
    assign wdat_a[gi] = wr_data[gi*DW +: DW];
  end

  // Rotate requests so bit 0 is the channel at rr_ptr; lowest set bit wins.
  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [IW-1:0]     arb_off;
  logic [IW:0]       arb_sum;
  logic [IW-1:0]     arb_pick;
  logic [IW:0]       ptr_inc;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[rr_ptr_q +: N_CH];

  always_comb begin
    arb_off = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (req_rot[i]) arb_off = IW'(i);
    end
    arb_sum = {1'b0, rr_ptr_q} + {1'b0, arb_off};
    if (arb_sum >= N_CH_W) arb_sum = arb_sum - N_CH_W;
    arb_pick = arb_sum[IW-1:0];
    ptr_inc  = {1'b0, g_q} + (IW+1)'(1);
    if (ptr_inc == N_CH_W) ptr_inc = '0;
  end

  logic wr_fire, rd_fire, last_word;

  assign wr_fire   = (state_q == S_WR_DATA) & wr_valid[g_q] & ~p_wr_full;
  assign rd_fire   = (state_q == S_RD_DATA) & ~p_rd_empty;
  assign last_word = (wcnt_q == {1'b0, bl_q});

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    bl_d     = bl_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (calib_done && (|req)) begin
          grant_d           = '0;
          grant_d[arb_pick] = 1'b1;
          g_d               = arb_pick;
          we_d              = req_we[arb_pick];
          instr_d           = req_we[arb_pick] ? 3'b000 : 3'b001;
          addr_d            = addr_a[arb_pick];
          bl_d              = bl_a[arb_pick];
          wcnt_d            = '0;
          state_d           = req_we[arb_pick] ? S_WR_DATA : S_CMD;
        end
      end
      S_WR_DATA: begin
        if (wr_fire) begin
          wcnt_d = wcnt_q + (BLW+1)'(1);
          if (last_word) state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!p_cmd_full) begin
          wcnt_d  = '0;
          state_d = we_q ? S_DONE : S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rd_fire) begin
          wcnt_d = wcnt_q + (BLW+1)'(1);
          if (last_word) state_d = S_DONE;
        end
      end
      S_DONE: begin
        grant_d  = '0;
        rr_ptr_d = ptr_inc[IW-1:0];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      g_q      <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      instr_q  <= 3'b000;
      addr_q   <= '0;
      bl_q     <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      bl_q     <= bl_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign grant           = grant_q;
  assign done            = (state_q == S_DONE) ? grant_q : '0;
  assign busy            = (state_q != S_IDLE);
  assign p_cmd_en        = (state_q == S_CMD) & ~p_cmd_full;
  assign p_cmd_instr     = instr_q;
  assign p_cmd_bl        = bl_q;
  assign p_cmd_byte_addr = addr_q;
  assign p_wr_en         = wr_fire;
  assign wr_ready        = wr_fire ? grant_q : '0;
  assign p_wr_data       = (state_q == S_WR_DATA) ? wdat_a[g_q] : '0;
  assign p_wr_mask       = '0;
  assign p_rd_en         = rd_fire;
  assign rd_valid        = rd_fire ? grant_q : '0;
  assign rd_data         = (state_q == S_RD_DATA) ? p_rd_data : '0;

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Scoreboard bench for mcb_port_arbiter: stimulus pushes expected port/client events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_mcb_port_arbiter;
  localparam int N = 4, DW = 32, AW = 30, BLW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            calib_done;
  logic [N-1:0]    req, req_we, wv, wr_ready, rd_valid, grant, done;
  logic [N*AW-1:0] req_addr;
  logic [N*BLW-1:0] req_bl;
  logic [N*DW-1:0] wr_data;
  logic [DW-1:0]   rd_data, p_wr_data, rdat;
  logic            busy, p_cmd_en, p_cmd_full, p_wr_en, p_wr_full = 1'b0, p_rd_en, p_rd_empty;
  logic [2:0]      p_cmd_instr;
  logic [BLW-1:0]  p_cmd_bl;
  logic [AW-1:0]   p_cmd_byte_addr;
  logic [DW/8-1:0] p_wr_mask;
  logic            tog = 1'b0;

  mcb_port_arbiter #(.N_CH(N), .DW(DW), .AW(AW), .BLW(BLW)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_bl(req_bl),
    .wr_data(wr_data), .wr_valid(wv), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .grant(grant), .done(done), .busy(busy),
    .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
    .p_wr_en(p_wr_en), .p_wr_data(p_wr_data), .p_wr_mask(p_wr_mask), .p_wr_full(p_wr_full),
    .p_rd_en(p_rd_en), .p_rd_data(rdat), .p_rd_empty(p_rd_empty)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wcount = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (p_wr_en) wcount <= wcount + 1;
  always @(posedge clk) p_wr_full <= tog ? ~p_wr_full : 1'b0;

  // Client write sources: each channel presents wsrc[c][widx[c]] and advances on wr_ready.
  logic [DW-1:0] wsrc [N][256];
  int widx [N];
  initial for (int c = 0; c < N; c++) widx[c] = 0;
  always @(posedge clk) begin
    for (int c = 0; c < N; c++) if (wr_ready[c]) widx[c] <= widx[c] + 1;
  end
  for (genvar gi = 0; gi < N; gi++) begin : g_src
    assign wr_data[gi*DW +: DW] = wsrc[gi][widx[gi] % 256];
  end

  localparam int K_GRANT = 0, K_WR = 1, K_CMD = 2, K_RD = 3, K_DONE = 4;
  typedef struct {
    int          kind;
    int          ch;
    logic [31:0] data;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
    int          cyc;
  } ev_t;
  ev_t expq[$];

  function automatic ev_t mk(int kind, int ch, logic [31:0] data, logic [2:0] instr,
                             logic [5:0] bl, logic [29:0] addr, int c);
    ev_t e;
    e.kind = kind; e.ch = ch; e.data = data; e.instr = instr; e.bl = bl; e.addr = addr; e.cyc = c;
    return e;
  endfunction

  function automatic int oh2idx(logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void push(ev_t e);
    expq.push_back(e);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic got(ev_t a);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d ch=%0d data=%h instr=%0d bl=%0d addr=%h cyc=%0d expected none",
               a.kind, a.ch, a.data, a.instr, a.bl, a.addr, a.cyc);
      return;
    end
    e = expq.pop_front();
    if (a.kind == e.kind && a.ch == e.ch && a.data === e.data && a.instr === e.instr &&
        a.bl === e.bl && a.addr === e.addr && (e.cyc < 0 || e.cyc == a.cyc)) begin
      passes++;
      $display("ok   event kind=%0d ch=%0d data=%h instr=%0d bl=%0d addr=%h cyc=%0d",
               a.kind, a.ch, a.data, a.instr, a.bl, a.addr, a.cyc);
    end else begin
      $display("FAIL event: got kind=%0d ch=%0d data=%h instr=%0d bl=%0d addr=%h cyc=%0d expected kind=%0d ch=%0d data=%h instr=%0d bl=%0d addr=%h cyc=%0d",
               a.kind, a.ch, a.data, a.instr, a.bl, a.addr, a.cyc,
               e.kind, e.ch, e.data, e.instr, e.bl, e.addr, e.cyc);
    end
  endtask

  logic [N-1:0] prev_grant = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (grant != '0 && prev_grant == '0) got(mk(K_GRANT, oh2idx(grant), 0, 0, 0, 0, cyc));
      if (p_wr_en) got(mk(K_WR, oh2idx(wr_ready), p_wr_data, 0, 0, 0, cyc));
      if (p_cmd_en) got(mk(K_CMD, 0, 0, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr, cyc));
      if (rd_valid != '0) got(mk(K_RD, oh2idx(rd_valid), rd_data, 0, 0, 0, cyc));
      if (done != '0) got(mk(K_DONE, oh2idx(done), 0, 0, 0, 0, cyc));
      prev_grant = grant;
    end else begin
      prev_grant = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int ch, logic we, logic [29:0] a, logic [5:0] b);
    req_we[ch] = we;
    req_addr[ch*AW +: AW] = a;
    req_bl[ch*BLW +: BLW] = b;
    req[ch] = 1'b1;
  endtask

  task automatic wait_done(int ch, int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done[ch]) seen = 1;
    end
    checks++;
    if (seen) passes++;
    else $display("FAIL wait_done_ch%0d: got no done within %0d cycles required done", ch, budget);
  endtask

  task automatic push_read(int ch, logic [29:0] a, logic [5:0] b, logic [31:0] d, int g);
    push(mk(K_GRANT, ch, 0, 0, 0, 0, g));
    push(mk(K_CMD, 0, 0, 3'b001, b, a, g));
    for (int i = 0; i <= int'(b); i++) push(mk(K_RD, ch, d, 0, 0, 0, g + 1 + i));
    push(mk(K_DONE, ch, 0, 0, 0, 0, g + 2 + int'(b)));
  endtask

  initial begin
    int t, w0;
    bit ok8;
    calib_done = 1'b0; req = '0; req_we = '0; req_addr = '0; req_bl = '0; wv = '0;
    p_cmd_full = 1'b0; p_rd_empty = 1'b0; rdat = '0;

    // Reset state
    repeat (3) tick();
    check("reset_grant_done_busy_cmd", {grant, done, busy, p_cmd_en}, 0);
    check("reset_cmd_fields", {p_cmd_instr, p_cmd_bl, p_cmd_byte_addr}, 0);
    check("reset_strobes", {p_wr_en, p_rd_en, wr_ready, rd_valid}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // calib_done low blocks grants even with all channels requesting
    for (int c = 0; c < N; c++) set_req(c, 1'b0, 30'(c * 'h40), 6'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("calib_block_busy_grant", {busy, grant}, 0);
    end
    rdat = 32'h0BAD_CAFE;
    calib_done = 1'b1;
    t = cyc;
    push_read(0, 30'h0, 6'd0, 32'h0BAD_CAFE, t + 1);
    tick();
    req = 4'b0001;
    wait_done(0, 20);
    req = '0;
    tick();

    // Write ch0, bl=3, 0xA0..0xA3
    for (int i = 0; i < 4; i++) wsrc[0][(widx[0] + i) % 256] = 32'hA0 + 32'(i);
    wv[0] = 1'b1;
    set_req(0, 1'b1, 30'h100, 6'd3);
    t = cyc;
    push(mk(K_GRANT, 0, 0, 0, 0, 0, t + 1));
    for (int i = 0; i < 4; i++) push(mk(K_WR, 0, 32'hA0 + 32'(i), 0, 0, 0, t + 1 + i));
    push(mk(K_CMD, 0, 0, 3'b000, 6'd3, 30'h100, t + 5));
    push(mk(K_DONE, 0, 0, 0, 0, 0, t + 6));
    wait_done(0, 30);
    req[0] = 1'b0; wv[0] = 1'b0;
    tick();

    // Read ch2, bl=0
    rdat = 32'hDEAD_BEEF;
    set_req(2, 1'b0, 30'h300, 6'd0);
    t = cyc;
    push_read(2, 30'h300, 6'd0, 32'hDEAD_BEEF, t + 1);
    wait_done(2, 20);
    req[2] = 1'b0;
    tick();

    // Write ch3, bl=7, with p_wr_full toggling and 3 cycles of p_cmd_full
    for (int i = 0; i < 8; i++) wsrc[3][(widx[3] + i) % 256] = 32'hC0 + 32'(i);
    wv[3] = 1'b1;
    p_cmd_full = 1'b1;
    tog = 1'b1;
    w0 = wcount;
    set_req(3, 1'b1, 30'h200, 6'd7);
    t = cyc;
    push(mk(K_GRANT, 3, 0, 0, 0, 0, t + 1));
    for (int i = 0; i < 8; i++) push(mk(K_WR, 3, 32'hC0 + 32'(i), 0, 0, 0, -1));
    ok8 = 0;
    for (int i = 0; i < 100 && !ok8; i++) begin
      tick();
      if (wcount - w0 == 8) ok8 = 1;
    end
    check("wr_stall_word_count", 64'(wcount - w0), 8);
    repeat (3) tick();
    t = cyc;
    push(mk(K_CMD, 0, 0, 3'b000, 6'd7, 30'h200, t));
    push(mk(K_DONE, 3, 0, 0, 0, 0, t + 1));
    p_cmd_full = 1'b0;
    tog = 1'b0;
    wait_done(3, 10);
    req[3] = 1'b0; wv[3] = 1'b0;
    tick();

    // Round robin: all four channels hold read requests, rr_ptr is back at 0
    rdat = 32'h1234_5678;
    for (int c = 0; c < N; c++) set_req(c, 1'b0, 30'(32'h1000 + c * 'h40), 6'd1);
    t = cyc;
    for (int k = 0; k < 6; k++)
      push_read(k % N, 30'(32'h1000 + (k % N) * 'h40), 6'd1, 32'h1234_5678, t + 1 + 5 * k);
    repeat (29) tick();
    req = '0;
    repeat (3) tick();

    // Reset during a 5-word read after 2 words
    rdat = 32'h5A5A_0001;
    set_req(3, 1'b0, 30'h400, 6'd4);
    t = cyc;
    push(mk(K_GRANT, 3, 0, 0, 0, 0, t + 1));
    push(mk(K_CMD, 0, 0, 3'b001, 6'd4, 30'h400, t + 1));
    push(mk(K_RD, 3, 32'h5A5A_0001, 0, 0, 0, t + 2));
    push(mk(K_RD, 3, 32'h5A5A_0001, 0, 0, 0, t + 3));
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort_ctrl_outputs", {grant, done, busy, p_cmd_en, p_wr_en, p_rd_en, wr_ready, rd_valid}, 0);
    check("abort_data_outputs", {rd_data, p_cmd_instr, p_cmd_bl}, 0);
    check("abort_events_consumed", 64'(expq.size()), 0);
    req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", {busy, grant}, 0);

    // rr_ptr restarted at 0: ch1 wins over ch3, then ch3
    rdat = 32'h0000_0077;
    set_req(1, 1'b0, 30'h500, 6'd0);
    set_req(3, 1'b0, 30'h600, 6'd0);
    t = cyc;
    push_read(1, 30'h500, 6'd0, 32'h77, t + 1);
    push_read(3, 30'h600, 6'd0, 32'h77, t + 5);
    wait_done(1, 20);
    req[1] = 1'b0;
    wait_done(3, 20);
    req[3] = 1'b0;

    repeat (5) tick();
    check("scoreboard_drained", 64'(expq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
